// File: rtl/ibuffer_mq.sv
// ============================================================================
// Module      : ibuffer_mq
// Description : Multi-warp instruction buffer. Each warp has its own FIFO.
//               A round-robin arbiter feeds a registered output stage, and
//               the next candidate is exposed one cycle early. Each warp
//               queue can be flushed on its own.
//               Optional: IBUFFER_PERF_EN adds stall and full cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ibuffer_mq #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 4,
  parameter int DATAW     = 128,
  parameter int WIDW      = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enq_valid,
  input  logic [WIDW-1:0]      enq_wid,
  input  logic [DATAW-1:0]     enq_data,
  output logic                 enq_ready,
  output logic [NUM_WARPS-1:0] full_mask,
  input  logic                 flush_valid,
  input  logic [WIDW-1:0]      flush_wid,
  output logic                 deq_valid,
  output logic [WIDW-1:0]      deq_wid,
  output logic [DATAW-1:0]     deq_data,
  input  logic                 deq_ready,
  output logic                 deq_valid_n,
  output logic [WIDW-1:0]      deq_wid_n,
  output logic [DATAW-1:0]     deq_data_n
`ifdef IBUFFER_PERF_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_full_cycles
`endif
);

  localparam int c_ptrw = $clog2(DEPTH);
  localparam int c_cntw = c_ptrw + 1;

  logic [DATAW-1:0]  r_mem    [NUM_WARPS][DEPTH];
  logic [c_ptrw-1:0] r_rd_ptr [NUM_WARPS];
  logic [c_ptrw-1:0] r_wr_ptr [NUM_WARPS];
  logic [c_cntw-1:0] r_count  [NUM_WARPS];
  logic [WIDW-1:0]   r_rr_ptr;
  logic              r_deq_valid;
  logic [WIDW-1:0]   r_deq_wid;
  logic [DATAW-1:0]  r_deq_data;

  logic [NUM_WARPS-1:0] w_full;
  logic [NUM_WARPS-1:0] w_elig;
  logic [NUM_WARPS-1:0] w_flush_hit;
  logic [NUM_WARPS-1:0] w_push;
  logic [NUM_WARPS-1:0] w_pop;
  logic                 w_enq_fire;
  logic                 w_out_free;
  logic                 w_load;
  logic                 w_found;
  logic [WIDW-1:0]      w_sel;

  generate
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp_flags
      assign w_full[g]      = (r_count[g] == c_cntw'(DEPTH));
      assign w_flush_hit[g] = flush_valid && (flush_wid == WIDW'(g));
      assign w_elig[g]      = (r_count[g] != '0) && !w_flush_hit[g];
      assign w_push[g]      = w_enq_fire && (enq_wid == WIDW'(g));
      assign w_pop[g]       = w_load && (w_sel == WIDW'(g));
    end
  endgenerate

  assign full_mask  = w_full;
  assign enq_ready  = !w_full[enq_wid] && !(flush_valid && (flush_wid == enq_wid));
  assign w_enq_fire = enq_valid && enq_ready;

  // Round-robin scan starting just after the last warp served.
  always_comb begin : p_select
    int              k;
    logic [WIDW-1:0] v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    k       = 0;
    v_idx   = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      k     = (int'(r_rr_ptr) + i) % NUM_WARPS;
      v_idx = WIDW'(k);
      if (!w_found && w_elig[v_idx]) begin
        w_found = 1'b1;
        w_sel   = v_idx;
      end
    end
  end

  assign deq_valid_n = w_found;
  assign deq_wid_n   = w_found ? w_sel : '0;
  assign deq_data_n  = w_found ? r_mem[w_sel][r_rd_ptr[w_sel]] : '0;

  // A held output belonging to the flushed warp is discarded as well.
  assign w_out_free = !r_deq_valid || deq_ready ||
                      (flush_valid && (flush_wid == r_deq_wid));
  assign w_load     = w_out_free && w_found;

  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[enq_wid][r_wr_ptr[enq_wid]] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        r_rd_ptr[w] <= '0;
        r_wr_ptr[w] <= '0;
        r_count[w]  <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (w_flush_hit[w]) begin
          r_rd_ptr[w] <= '0;
          r_wr_ptr[w] <= '0;
          r_count[w]  <= '0;
        end else begin
          if (w_push[w]) r_wr_ptr[w] <= r_wr_ptr[w] + c_ptrw'(1);
          if (w_pop[w])  r_rd_ptr[w] <= r_rd_ptr[w] + c_ptrw'(1);
          case ({w_push[w], w_pop[w]})
            2'b10:   r_count[w] <= r_count[w] + c_cntw'(1);
            2'b01:   r_count[w] <= r_count[w] - c_cntw'(1);
            default: r_count[w] <= r_count[w];
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deq_valid <= 1'b0;
      r_deq_wid   <= '0;
      r_deq_data  <= '0;
      r_rr_ptr    <= WIDW'(NUM_WARPS - 1);
    end else if (w_out_free) begin
      if (w_found) begin
        r_deq_valid <= 1'b1;
        r_deq_wid   <= w_sel;
        r_deq_data  <= deq_data_n;
        r_rr_ptr    <= w_sel;
      end else begin
        r_deq_valid <= 1'b0;
      end
    end
  end

  assign deq_valid = r_deq_valid;
  assign deq_wid   = r_deq_wid;
  assign deq_data  = r_deq_data;

`ifdef IBUFFER_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_stall <= '0;
      r_perf_full  <= '0;
    end else begin
      if (r_deq_valid && !deq_ready) r_perf_stall <= r_perf_stall + 32'd1;
      if (enq_valid && !enq_ready)   r_perf_full  <= r_perf_full + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf_stall;
  assign perf_full_cycles  = r_perf_full;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ibuffer_mq.sv
// ============================================================================
// Module      : tb_ibuffer_mq
// Description : Randomized scoreboard bench for ibuffer_mq against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibuffer_mq;

  localparam int NUM_WARPS = 4;
  localparam int DEPTH     = 4;
  localparam int DATAW     = 128;
  localparam int WIDW      = 2;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 enq_valid = 1'b0;
  logic [WIDW-1:0]      enq_wid = '0;
  logic [DATAW-1:0]     enq_data = '0;
  logic                 enq_ready;
  logic [NUM_WARPS-1:0] full_mask;
  logic                 flush_valid = 1'b0;
  logic [WIDW-1:0]      flush_wid = '0;
  logic                 deq_valid;
  logic [WIDW-1:0]      deq_wid;
  logic [DATAW-1:0]     deq_data;
  logic                 deq_ready = 1'b0;
  logic                 deq_valid_n;
  logic [WIDW-1:0]      deq_wid_n;
  logic [DATAW-1:0]     deq_data_n;
`ifdef IBUFFER_PERF_EN
  logic [31:0]          perf_stall_cycles;
  logic [31:0]          perf_full_cycles;
`endif

  always #5 clk = ~clk;

  ibuffer_mq #(
    .NUM_WARPS (NUM_WARPS),
    .DEPTH     (DEPTH),
    .DATAW     (DATAW),
    .WIDW      (WIDW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enq_valid   (enq_valid),
    .enq_wid     (enq_wid),
    .enq_data    (enq_data),
    .enq_ready   (enq_ready),
    .full_mask   (full_mask),
    .flush_valid (flush_valid),
    .flush_wid   (flush_wid),
    .deq_valid   (deq_valid),
    .deq_wid     (deq_wid),
    .deq_data    (deq_data),
    .deq_ready   (deq_ready),
    .deq_valid_n (deq_valid_n),
    .deq_wid_n   (deq_wid_n),
    .deq_data_n  (deq_data_n)
`ifdef IBUFFER_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_full_cycles  (perf_full_cycles)
`endif
  );

  // Reference model: one plain queue per warp plus an output slot.
  logic [DATAW-1:0]      mq [NUM_WARPS][$];
  bit                    m_valid;
  int                    m_wid;
  logic [DATAW-1:0]      m_data;
  int                    m_last;
  logic [31:0]           m_stall;
  logic [31:0]           m_full;
  logic [WIDW+DATAW-1:0] sb [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [DATAW-1:0] act, input logic [DATAW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_pick(input bit fv, input int fw);
    for (int i = 1; i <= NUM_WARPS; i++) begin
      int w;
      w = (m_last + i) % NUM_WARPS;
      if (mq[w].size() > 0 && !(fv && fw == w)) return w;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < NUM_WARPS; w++) mq[w].delete();
    m_valid = 1'b0;
    m_wid   = 0;
    m_data  = '0;
    m_last  = NUM_WARPS - 1;
    m_stall = '0;
    m_full  = '0;
    sb.delete();
  endtask

  function automatic logic [DATAW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic cycle(input bit ev, input int ew, input logic [DATAW-1:0] ed,
                       input bit fv, input int fw, input bit dr);
    int                   c;
    bit                   er;
    logic [NUM_WARPS-1:0] fm;
    @(negedge clk);
    enq_valid   = ev;
    enq_wid     = WIDW'(ew);
    enq_data    = ed;
    flush_valid = fv;
    flush_wid   = WIDW'(fw);
    deq_ready   = dr;
    #1;
    c  = m_pick(fv, fw);
    er = (mq[ew].size() < DEPTH) && !(fv && fw == ew);
    fm = '0;
    for (int w = 0; w < NUM_WARPS; w++) fm[w] = (mq[w].size() == DEPTH);
    chk("enq_ready", DATAW'(enq_ready), DATAW'(er));
    chk("full_mask", DATAW'(full_mask), DATAW'(fm));
    chk("deq_valid_n", DATAW'(deq_valid_n), DATAW'(c >= 0));
    if (c >= 0) begin
      chk("deq_wid_n", DATAW'(deq_wid_n), DATAW'(c));
      chk("deq_data_n", deq_data_n, mq[c][0]);
    end else begin
      chk("deq_wid_n_idle", DATAW'(deq_wid_n), '0);
      chk("deq_data_n_idle", deq_data_n, '0);
    end
    chk("deq_valid", DATAW'(deq_valid), DATAW'(m_valid));
    if (m_valid) begin
      chk("deq_wid", DATAW'(deq_wid), DATAW'(m_wid));
      chk("deq_data", deq_data, m_data);
    end
`ifdef IBUFFER_PERF_EN
    chk("perf_stall", DATAW'(perf_stall_cycles), DATAW'(m_stall));
    chk("perf_full", DATAW'(perf_full_cycles), DATAW'(m_full));
`endif
    // Advance the model to the state after the coming rising edge.
    if (m_valid && !dr) m_stall++;
    if (ev && !er) m_full++;
    if (m_valid && dr) sb.push_back({WIDW'(m_wid), m_data});
    if (!m_valid || dr || (fv && m_wid == fw)) begin
      if (c >= 0) begin
        m_data  = mq[c].pop_front();
        m_wid   = c;
        m_valid = 1'b1;
        m_last  = c;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (fv) mq[fw].delete();
    if (ev && er) mq[ew].push_back(ed);
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, '0, 1'b0, 0, dr);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    enq_valid   = 1'b0;
    flush_valid = 1'b0;
    deq_ready   = 1'b0;
    #3;
    reset = 1'b0;
    #1;
    chk("rst_deq_valid", DATAW'(deq_valid), '0);
    chk("rst_full_mask", DATAW'(full_mask), '0);
    chk("rst_deq_valid_n", DATAW'(deq_valid_n), '0);
    model_reset();
    repeat (2) @(negedge clk);
    #3;
    reset = 1'b1;
  endtask

  // Monitor: every accepted output must match the next scoreboard entry.
  initial begin : p_monitor
    logic [WIDW+DATAW-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset && deq_valid && deq_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL sb_underflow: got output wid %0d, expected no output", deq_wid);
        end else begin
          e = sb.pop_front();
          chk("sb_wid", DATAW'(deq_wid), DATAW'(e[WIDW+DATAW-1:DATAW]));
          chk("sb_data", deq_data, e[DATAW-1:0]);
        end
      end
    end
  end

  initial begin : p_stim
    int pe;
    int pr;
    int pf;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_deq_valid", DATAW'(deq_valid), '0);
    chk("reset_deq_wid", DATAW'(deq_wid), '0);
    chk("reset_deq_data", deq_data, '0);
    chk("reset_full_mask", DATAW'(full_mask), '0);
    chk("reset_enq_ready", DATAW'(enq_ready), DATAW'(1));
    #2;
    reset = 1'b1;

    // Single instruction latency.
    cycle(1'b1, 2, DATAW'(8'hA5), 1'b0, 0, 1'b1);
    idle(4, 1'b1);

    // Fill warp 1 past capacity while warp 0 still accepts.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1, rnd_data(), 1'b0, 0, 1'b0);
    cycle(1'b1, 0, rnd_data(), 1'b0, 0, 1'b0);
    cycle(1'b0, 0, '0, 1'b1, 1, 1'b0);
    idle(6, 1'b1);

    // Round-robin over warps 0, 1 and 3.
    for (int r = 0; r < 2; r++) begin
      cycle(1'b1, 0, rnd_data(), 1'b0, 0, 1'b0);
      cycle(1'b1, 1, rnd_data(), 1'b0, 0, 1'b0);
      cycle(1'b1, 3, rnd_data(), 1'b0, 0, 1'b0);
    end
    idle(8, 1'b1);

    // Output stall for five cycles.
    cycle(1'b1, 2, rnd_data(), 1'b0, 0, 1'b0);
    idle(5, 1'b0);
    idle(3, 1'b1);

    // Randomized traffic in several load profiles.
    for (int ph = 0; ph < 4; ph++) begin
      case (ph)
        0:       begin pe = 80; pr = 30; pf = 3;  end
        1:       begin pe = 50; pr = 90; pf = 2;  end
        2:       begin pe = 90; pr = 90; pf = 5;  end
        default: begin pe = 30; pr = 50; pf = 10; end
      endcase
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom_range(99) < pe), int'($urandom_range(NUM_WARPS - 1)), rnd_data(),
              ($urandom_range(99) < pf), int'($urandom_range(NUM_WARPS - 1)),
              ($urandom_range(99) < pr));
      end
    end

    // Reset in the middle of traffic with every queue populated.
    for (int w = 0; w < NUM_WARPS; w++) begin
      cycle(1'b1, w, rnd_data(), 1'b0, 0, 1'b0);
      cycle(1'b1, w, rnd_data(), 1'b0, 0, 1'b0);
    end
    mid_reset();
    cycle(1'b1, 0, rnd_data(), 1'b0, 0, 1'b1);
    idle(4, 1'b1);

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(99) < 60), int'($urandom_range(NUM_WARPS - 1)), rnd_data(),
            ($urandom_range(99) < 4), int'($urandom_range(NUM_WARPS - 1)),
            ($urandom_range(99) < 70));
    end
    idle(12, 1'b1);

    chk("sb_leftover", DATAW'(sb.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
